// File: rtl/alu_rom_sequencer_if.sv
// alu_rom_sequencer_if: ROM fetch and shared ALU bus between sequencer (master) and ROM/ALU (slave)
interface alu_rom_sequencer_if #(
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [15:0]       rom_data;
  logic [7:0]        alu_n1;
  logic [7:0]        alu_n2;
  logic [3:0]        alu_op;
  logic [7:0]        alu_s1;
  modport master (output rom_addr, rom_en, alu_n1, alu_n2, alu_op, input rom_data, alu_s1);
  modport slave (input rom_addr, rom_en, alu_n1, alu_n2, alu_op, output rom_data, alu_s1);
endinterface

// File: rtl/alu_rom_sequencer.sv
// alu_rom_sequencer: ROM-program microsequencer over an external 8-bit ALU; ALU_SEQ_BRANCH_EN adds Z flag and BRZ
module alu_rom_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int MAX_STEPS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [7:0]                 acc,
  input  logic [1:0]                 dbg_sel,
  output logic [7:0]                 dbg_data,
  alu_rom_sequencer_if.master        bus
);
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, DONE = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SW-1:0]     steps_q, steps_d;
  logic [15:0]       ir_q, ir_d;
  logic [7:0]        regs_q [4];
  logic [7:0]        regs_d [4];
  logic              err_q, err_d;
  logic [7:0]        acc_q, acc_d;
  logic [3:0]        op;
  logic [1:0]        rd, rs;
  logic [7:0]        imm, wdata;
  logic              wr, brz, taken, halt_in, limit;
  assign op    = ir_q[15:12];
  assign rd    = ir_q[11:10];
  assign rs    = ir_q[9:8];
  assign imm   = ir_q[7:0];
  assign wdata = op == 4'hE ? imm : bus.alu_s1;
  assign wr    = state_q == EXEC && !brz;
`ifdef ALU_SEQ_BRANCH_EN
  logic z_q, z_d;
  assign brz   = op == 4'h9;
  assign taken = brz && z_q;
  assign z_d   = state_q == IDLE && start ? 1'b0 : wr ? wdata == 8'd0 : z_q;
  always_ff @(posedge clk)
    z_q <= !rst_n ? 1'b0 : z_d;
`else
  assign brz   = 1'b0;
  assign taken = 1'b0;
`endif
  assign halt_in = bus.rom_data[15:12] == 4'hF;
  assign limit   = steps_q == SW'(MAX_STEPS);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    steps_d = steps_q;
    ir_d    = ir_q;
    err_d   = err_q;
    acc_d   = acc_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        pc_d    = '0;
        steps_d = '0;
        err_d   = 1'b0;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d    = bus.rom_data;
        state_d = halt_in || limit ? DONE : EXEC;
        err_d   = !halt_in && limit;
      end
      EXEC: begin
        if (wr) begin
          regs_d[rd] = wdata;
          acc_d      = wdata;
        end
        pc_d    = taken ? imm[ADDR_W-1:0] : pc_q + 1'b1;
        steps_d = steps_q + 1'b1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      steps_q <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      steps_q <= steps_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      regs_q  <= regs_d;
    end
  assign bus.rom_en   = state_q == FETCH;
  assign bus.rom_addr = pc_q;
  assign bus.alu_op   = op;
  assign bus.alu_n1   = regs_q[rs];
  assign bus.alu_n2   = imm;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign err          = err_q;
  assign acc          = acc_q;
  assign dbg_data     = regs_q[dbg_sel];
endmodule
